// File: rtl/mon_dram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mon_arb_defs
// Shared definitions for the data-RAM arbiter between the CPU load/store unit
// and the UART monitor: port-owner state encoding and default starvation
// parameters.
// Optional feature macro used by the arbiter: MON_DRAM_ARB_STAT_EN.
// -----------------------------------------------------------------------------
package mon_arb_defs;

  // Port owner: CPU, monitor, or one turnaround cycle after the monitor
  // releases the port.
  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_MON   = 2'd1,
    S_GUARD = 2'd2
  } arb_state_t;

  // The starvation counter width must satisfy 2^DEF_SCNT_W > DEF_STARVE_LIMIT.
  localparam int DEF_STARVE_LIMIT = 1024;
  localparam int DEF_SCNT_W       = 11;

endpackage

// File: rtl/mon_dram_arbiter_starve_cntr.sv
// -----------------------------------------------------------------------------
// arb_starve_cntr
// Counts consecutive cycles in which the CPU waits for the data-RAM port and
// raises a sticky starvation flag once the count reaches STARVE_LIMIT.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   wait_cyc   in   CPU is requesting but not granted this cycle
//   starve_clr in   clears the sticky flag (a simultaneous set wins)
//   starve     out  sticky starvation flag
// -----------------------------------------------------------------------------
module arb_starve_cntr
  import mon_arb_defs::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int SCNT_W       = DEF_SCNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_cyc,
  input  logic starve_clr,
  output logic starve
);

  localparam logic [SCNT_W-1:0] LIMIT = SCNT_W'(STARVE_LIMIT);

  logic [SCNT_W-1:0] cnt;
  logic [SCNT_W-1:0] cnt_next;

  // Saturating count of the current run of wait cycles; any cycle that is
  // not a wait (grant or no request) ends the run.
  always_comb begin
    cnt_next = '0;
    if (wait_cyc) begin
      cnt_next = (cnt == LIMIT) ? LIMIT : cnt + SCNT_W'(1);
    end
  end

  // The flag is set on the same edge at which the count reaches the limit,
  // so it is the set term that wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      starve <= (cnt_next == LIMIT) | (starve & ~starve_clr);
    end
  end

endmodule

// File: rtl/mon_dram_arbiter.sv
// -----------------------------------------------------------------------------
// mon_dram_arbiter
// Shares the single data-RAM port (one write port, one synchronous read port
// with 1-cycle latency) between the CPU load/store unit and the UART monitor.
// The monitor cannot be stalled and wins combinationally; the CPU uses a
// req/gnt handshake and waits while the monitor owns the port.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_adr/cpu_wdata    CPU request (held until granted)
//   cpu_gnt                             access performed this cycle
//   cpu_rdata/cpu_rvalid                CPU read data, valid one cycle after a
//                                       granted read
//   mon_wen/mon_wadr/mon_wdata          monitor write
//   mon_read_sel/mon_radr/mon_rdata     monitor dump read
//   ram_wen/ram_wadr/ram_wdata          RAM write port
//   ram_radr/ram_rdata                  RAM read port
//   cpu_starve/starve_clr               sticky CPU starvation flag and clear
//   stat_cpu_cnt/stat_mon_cnt           grant / monitor-cycle counters, only
//                                       present with MON_DRAM_ARB_STAT_EN
// -----------------------------------------------------------------------------
module mon_dram_arbiter
  import mon_arb_defs::*;
#(
  parameter int DWIDTH       = 12,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int SCNT_W       = DEF_SCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DWIDTH-1:0] cpu_adr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              mon_wen,
  input  logic [DWIDTH-1:0] mon_wadr,
  input  logic [31:0]       mon_wdata,
  input  logic              mon_read_sel,
  input  logic [DWIDTH-1:0] mon_radr,
  output logic [31:0]       mon_rdata,
  output logic              ram_wen,
  output logic [DWIDTH-1:0] ram_wadr,
  output logic [31:0]       ram_wdata,
  output logic [DWIDTH-1:0] ram_radr,
  input  logic [31:0]       ram_rdata,
  output logic              cpu_starve,
  input  logic              starve_clr
`ifdef MON_DRAM_ARB_STAT_EN
  ,
  output logic [31:0]       stat_cpu_cnt,
  output logic [31:0]       stat_mon_cnt
`endif
);

  arb_state_t state;
  arb_state_t state_next;
  logic       mon_active;

  assign mon_active = mon_wen | mon_read_sel;

  // Both consumers see the same RAM read bus and qualify it by their own timing.
  assign cpu_rdata = ram_rdata;
  assign mon_rdata = ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CPU;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus port mux. The monitor takes the port in any state; after
  // it goes idle the port stays parked on the monitor addresses through the
  // MON and GUARD cycles so its last read completes undisturbed.
  always_comb begin
    state_next = state;
    ram_wen    = 1'b0;
    ram_wadr   = mon_wadr;
    ram_wdata  = mon_wdata;
    ram_radr   = mon_radr;
    cpu_gnt    = 1'b0;

    unique case (state)
      S_CPU:   if (mon_active) state_next = S_MON;
      S_MON:   if (!mon_active) state_next = S_GUARD;
      S_GUARD: state_next = mon_active ? S_MON : S_CPU;
      default: state_next = S_CPU;
    endcase

    if (mon_active) begin
      ram_wen = mon_wen;
    end else if (state == S_CPU) begin
      ram_radr  = cpu_adr;
      ram_wadr  = cpu_adr;
      ram_wdata = cpu_wdata;
      ram_wen   = cpu_req & cpu_we;
      cpu_gnt   = cpu_req;
    end
  end

  // Read valid follows a granted read by exactly one cycle regardless of who
  // owns the port in that next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
    end
  end

  arb_starve_cntr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SCNT_W       (SCNT_W)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .wait_cyc   (cpu_req & ~cpu_gnt),
    .starve_clr (starve_clr),
    .starve     (cpu_starve)
  );

`ifdef MON_DRAM_ARB_STAT_EN
  // Free-running usage counters; starve_clr restarts both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpu_cnt <= '0;
      stat_mon_cnt <= '0;
    end else if (starve_clr) begin
      stat_cpu_cnt <= '0;
      stat_mon_cnt <= '0;
    end else begin
      stat_cpu_cnt <= stat_cpu_cnt + {31'd0, cpu_gnt};
      stat_mon_cnt <= stat_mon_cnt + {31'd0, mon_active};
    end
  end
`endif

endmodule
